wb_scratch_ram: RTL and testbench

- Wishbone B4 slave: single-port, byte-writable scratch RAM.
- Sits directly downstream of the wb0 address decoder and is selected by the 0xb1xxxxxx window (mask 0xff000000).
- Supports classic single cycles and registered-feedback incrementing bursts (CTI/BTE), including linear and wrap-4/8/16 sequences.
- Flags out-of-range accesses with an error response.

---
 rtl/wb_scratch_ram_if.sv | 25 ++
 rtl/wb_scratch_ram.sv | 124 ++++++++++++
 tb/tb_wb_scratch_ram.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scratch_ram_if.sv
// rtl/wb_scratch_ram_if.sv - Wishbone B4 signal bundle between a master and wb_scratch_ram
interface wb_scratch_ram_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_scratch_ram.sv
// rtl/wb_scratch_ram.sv - Wishbone B4 byte-writable scratch RAM with classic and CTI/BTE burst cycles
module wb_scratch_ram #(
   parameter int MEM_WORDS = 1024,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_scratch_ram_if.slave wb
);
   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [21:0] MEM_LIMIT = 22'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

   state_t      state_q, state_d;
   logic [21:0] cur_idx_q, cur_idx_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] dat_o_q, dat_o_d;

   logic [31:0] mem [MEM_WORDS] = '{default: (INIT_ZERO ? 32'h0 : 32'hxxxx_xxxx)};

   logic [21:0] adr_idx;
   logic [21:0] next_idx;
   logic        burst_req;
   logic        commit;
   logic        unused_adr;

   assign adr_idx    = wb.wb_adr_i[23:2];
   assign burst_req  = (wb.wb_cti_i == 3'b010);
   assign unused_adr = ^{wb.wb_adr_i[31:24], wb.wb_adr_i[1:0]};

   // Writes land only on the edge that completes an acknowledged beat; reset abandons it.
   assign commit = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i & ack_q & ~wb_rst_i;

   always_comb begin
      case (wb.wb_bte_i)
         2'b01:   next_idx = {cur_idx_q[21:2], cur_idx_q[1:0] + 2'd1};
         2'b10:   next_idx = {cur_idx_q[21:3], cur_idx_q[2:0] + 3'd1};
         2'b11:   next_idx = {cur_idx_q[21:4], cur_idx_q[3:0] + 4'd1};
         default: next_idx = cur_idx_q + 22'd1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cur_idx_d = cur_idx_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_o_d   = dat_o_q;
      if (!wb.wb_cyc_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // An error response is still visible for one edge; do not relaunch on it.
               if (wb.wb_stb_i && !err_q) begin
                  cur_idx_d = adr_idx;
                  if (adr_idx < MEM_LIMIT) begin
                     dat_o_d = mem[adr_idx[AW-1:0]];
                     ack_d   = 1'b1;
                     state_d = burst_req ? BURST : CLASSIC;
                  end else begin
                     dat_o_d = '0;
                     err_d   = 1'b1;
                  end
               end
            end
            CLASSIC: begin
               state_d = IDLE;
            end
            BURST: begin
               if (!wb.wb_stb_i) begin
                  ack_d = 1'b0;
               end else if (!ack_q) begin
                  ack_d   = 1'b1;
                  dat_o_d = mem[cur_idx_q[AW-1:0]];
               end else if (!burst_req) begin
                  state_d = IDLE;
               end else if (next_idx >= MEM_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cur_idx_d = next_idx;
                  dat_o_d   = mem[next_idx[AW-1:0]];
                  ack_d     = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         cur_idx_q <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_o_q   <= '0;
      end else begin
         state_q   <= state_d;
         cur_idx_q <= cur_idx_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_o_q   <= dat_o_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (wb.wb_sel_i[b]) begin
               mem[cur_idx_q[AW-1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wb.wb_dat_o = dat_o_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_scratch_ram.sv
// tb/tb_wb_scratch_ram.sv - self-checking bench for wb_scratch_ram with a read-data scoreboard
module tb_wb_scratch_ram;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   logic [31:0] model [1024];
   logic [31:0] sb_q [$];
   logic [31:0] obs_dat [$];
   logic        obs_ack [$];
   logic        b_err, b_timeout, b_end_ack;
   int          b_done_beats;
   logic [2:0]  b_cti [16];
   logic        b_we  [16];
   logic [31:0] b_dat [16];

   wb_scratch_ram_if bus();

   wb_scratch_ram #(.MEM_WORDS(1024), .INIT_ZERO(1'b1)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] adr_of(input int idx);
      return 32'hb100_0000 | (32'(idx) << 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
   endtask

   task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] rd, output logic got_ack,
                          output logic got_err, output logic after);
      bus.wb_adr_i = a; bus.wb_we_i = w; bus.wb_dat_i = d; bus.wb_sel_i = s;
      bus.wb_cti_i = 3'b000; bus.wb_bte_i = 2'b00; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
      lat = -1; rd = '0; got_ack = 1'b0; got_err = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (bus.wb_ack_o || bus.wb_err_o) begin
            lat = i; rd = bus.wb_dat_o; got_ack = bus.wb_ack_o; got_err = bus.wb_err_o;
            break;
         end
      end
      tick();
      after = bus.wb_ack_o | bus.wb_err_o;
      bus_idle();
   endtask

   task automatic burst(input logic [31:0] a0, input logic [1:0] bte, input int n,
                        input int wait_after, input int wait_cycles);
      int k; int wcnt; logic ack_prev; logic stb_prev; logic a; logic e;
      k = 0; wcnt = 0; ack_prev = 1'b0;
      obs_dat.delete(); obs_ack.delete();
      b_err = 1'b0; b_timeout = 1'b1; b_end_ack = 1'b0;
      bus.wb_adr_i = a0; bus.wb_bte_i = bte; bus.wb_sel_i = 4'hf;
      bus.wb_cti_i = b_cti[0]; bus.wb_we_i = b_we[0]; bus.wb_dat_i = b_dat[0];
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
      for (int c = 0; c < 64; c++) begin
         stb_prev = bus.wb_stb_i;
         tick();
         a = bus.wb_ack_o; e = bus.wb_err_o;
         obs_ack.push_back(a);
         if (!stb_prev) begin
            wcnt--;
            if (wcnt <= 0) bus.wb_stb_i = 1'b1;
         end else if (ack_prev) begin
            k++;
            if (k == n) begin
               b_timeout = 1'b0; b_end_ack = a | e;
               break;
            end
            bus.wb_cti_i = b_cti[k]; bus.wb_we_i = b_we[k]; bus.wb_dat_i = b_dat[k];
            if (k == wait_after && wait_cycles > 0) begin
               bus.wb_stb_i = 1'b0; wcnt = wait_cycles;
            end
         end
         if (e) begin
            b_err = 1'b1; b_timeout = 1'b0;
            break;
         end
         if (a && bus.wb_stb_i && !bus.wb_we_i) obs_dat.push_back(bus.wb_dat_o);
         ack_prev = a;
      end
      b_done_beats = k;
      bus_idle();
      tick();
   endtask

   task automatic set_beats(input int n, input logic w, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         b_cti[i] = (i == n - 1) ? 3'b111 : 3'b010;
         b_we[i]  = w;
         b_dat[i] = base + 32'(i);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_idle();
      repeat (3) tick();
      checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", bus.wb_ack_o); end
      checks++; if (bus.wb_err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.wb_err_o); end
      checks++; if (bus.wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h expected 00000000", bus.wb_dat_o); end
      checks++; if (bus.wb_rty_o !== 1'b0) begin failures++; $display("FAIL reset_rty: got %b expected 0", bus.wb_rty_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_classic();
      int lat; logic [31:0] rd, exp; logic ga, ge, af;
      classic(32'hb100_0010, 1'b1, 32'hdeadbeef, 4'b1111, lat, rd, ga, ge, af);
      model_write(4, 32'hdeadbeef, 4'b1111);
      checks++; if (lat !== 1) begin failures++; $display("FAIL classic_wr_latency: got %0d expected 1", lat); end
      checks++; if (af !== 1'b0) begin failures++; $display("FAIL classic_wr_pulse: got %b expected 0", af); end
      classic(32'hb100_0010, 1'b1, 32'h000000aa, 4'b0001, lat, rd, ga, ge, af);
      model_write(4, 32'h000000aa, 4'b0001);
      checks++; if (lat !== 1) begin failures++; $display("FAIL classic_bytewr_latency: got %0d expected 1", lat); end
      sb_q.push_back(model[4]);
      classic(32'hb100_0010, 1'b0, 32'h0, 4'b0000, lat, rd, ga, ge, af);
      exp = sb_q.pop_front();
      checks++; if (rd !== exp) begin failures++; $display("FAIL classic_rd_data: got %h expected %h", rd, exp); end
      checks++; if (lat !== 1 || ga !== 1'b1 || af !== 1'b0) begin
         failures++; $display("FAIL classic_rd_ack: got lat=%0d ack=%b after=%b expected lat=1 ack=1 after=0", lat, ga, af);
      end
      sb_q.push_back(model[100]);
      classic(adr_of(100), 1'b0, 32'h0, 4'b0000, lat, rd, ga, ge, af);
      exp = sb_q.pop_front();
      checks++; if (rd !== exp) begin failures++; $display("FAIL init_zero: got %h expected %h", rd, exp); end
   endtask

   task automatic test_wrap4();
      int lat; logic [31:0] rd, exp; logic ga, ge, af; logic [15:0] tr;
      for (int i = 4; i < 8; i++) begin
         classic(adr_of(i), 1'b1, 32'(i), 4'hf, lat, rd, ga, ge, af);
         model_write(i, 32'(i), 4'hf);
      end
      set_beats(4, 1'b0, 32'h0);
      sb_q.push_back(model[6]); sb_q.push_back(model[7]);
      sb_q.push_back(model[4]); sb_q.push_back(model[5]);
      burst(32'hb100_0018, 2'b01, 4, -1, 0);
      checks++; if (b_timeout !== 1'b0 || b_err !== 1'b0) begin failures++; $display("FAIL wrap4_done: got timeout=%b err=%b expected 0 0", b_timeout, b_err); end
      checks++; if (obs_dat.size() !== 4) begin failures++; $display("FAIL wrap4_beats: got %0d expected 4", obs_dat.size()); end
      while (sb_q.size() > 0 && obs_dat.size() > 0) begin
         exp = sb_q.pop_front(); rd = obs_dat.pop_front();
         checks++; if (rd !== exp) begin failures++; $display("FAIL wrap4_data: got %h expected %h", rd, exp); end
      end
      sb_q.delete();
      tr = '0;
      foreach (obs_ack[i]) tr = {tr[14:0], obs_ack[i]};
      checks++; if (tr !== 16'b11110 || obs_ack.size() !== 5) begin failures++; $display("FAIL wrap4_ack_trace: got %b len %0d expected 11110 len 5", tr, obs_ack.size()); end
      classic(adr_of(5), 1'b0, 32'h0, 4'h0, lat, rd, ga, ge, af);
      checks++; if (lat !== 1) begin failures++; $display("FAIL wrap4_idle_after: got latency %0d expected 1", lat); end
   endtask

   task automatic test_linear_write();
      int lat; logic [31:0] rd, exp; logic ga, ge, af;
      classic(adr_of(12), 1'b1, 32'h12121212, 4'hf, lat, rd, ga, ge, af);
      model_write(12, 32'h12121212, 4'hf);
      set_beats(4, 1'b1, 32'h1);
      burst(adr_of(8), 2'b00, 4, -1, 0);
      for (int i = 0; i < 4; i++) model_write(8 + i, b_dat[i], 4'hf);
      checks++; if (b_timeout !== 1'b0 || b_end_ack !== 1'b0) begin failures++; $display("FAIL linwr_done: got timeout=%b end_ack=%b expected 0 0", b_timeout, b_end_ack); end
      for (int i = 8; i <= 12; i++) begin
         sb_q.push_back(model[i]);
         classic(adr_of(i), 1'b0, 32'h0, 4'h0, lat, rd, ga, ge, af);
         exp = sb_q.pop_front();
         checks++; if (rd !== exp) begin failures++; $display("FAIL linwr_readback idx %0d: got %h expected %h", i, rd, exp); end
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd, exp; logic ga, ge, af; logic [15:0] tr;
      classic(32'hb100_1000, 1'b0, 32'h0, 4'h0, lat, rd, ga, ge, af);
      checks++; if (ge !== 1'b1 || ga !== 1'b0 || lat !== 1 || af !== 1'b0) begin
         failures++; $display("FAIL oor_classic: got err=%b ack=%b lat=%0d after=%b expected 1 0 1 0", ge, ga, lat, af);
      end
      classic(adr_of(0), 1'b1, 32'ha5a5a5a5, 4'hf, lat, rd, ga, ge, af);
      model_write(0, 32'ha5a5a5a5, 4'hf);
      set_beats(4, 1'b1, 32'h0000_0f00);
      burst(adr_of(1022), 2'b00, 4, -1, 0);
      model_write(1022, b_dat[0], 4'hf);
      model_write(1023, b_dat[1], 4'hf);
      checks++; if (b_err !== 1'b1 || b_done_beats !== 2) begin failures++; $display("FAIL oor_burst_err: got err=%b beats=%0d expected 1 2", b_err, b_done_beats); end
      tr = '0;
      foreach (obs_ack[i]) tr = {tr[14:0], obs_ack[i]};
      checks++; if (tr !== 16'b110) begin failures++; $display("FAIL oor_burst_ack_trace: got %b expected 110", tr); end
      foreach (b_dat[i]) if (i == 0) begin end
      for (int j = 0; j < 3; j++) begin
         int idx;
         idx = (j == 2) ? 0 : 1022 + j;
         sb_q.push_back(model[idx]);
         classic(adr_of(idx), 1'b0, 32'h0, 4'h0, lat, rd, ga, ge, af);
         exp = sb_q.pop_front();
         checks++; if (rd !== exp) begin failures++; $display("FAIL oor_readback idx %0d: got %h expected %h", idx, rd, exp); end
      end
   endtask

   task automatic test_wait_state();
      logic [31:0] rd, exp; logic [15:0] tr;
      set_beats(4, 1'b0, 32'h0);
      for (int i = 4; i < 8; i++) sb_q.push_back(model[i]);
      burst(adr_of(4), 2'b00, 4, 2, 2);
      checks++; if (b_timeout !== 1'b0 || obs_dat.size() !== 4) begin failures++; $display("FAIL wait_done: got timeout=%b beats=%0d expected 0 4", b_timeout, obs_dat.size()); end
      while (sb_q.size() > 0 && obs_dat.size() > 0) begin
         exp = sb_q.pop_front(); rd = obs_dat.pop_front();
         checks++; if (rd !== exp) begin failures++; $display("FAIL wait_data: got %h expected %h", rd, exp); end
      end
      sb_q.delete();
      tr = '0;
      foreach (obs_ack[i]) tr = {tr[14:0], obs_ack[i]};
      checks++; if (tr !== 16'b11100110) begin failures++; $display("FAIL wait_ack_trace: got %b expected 11100110", tr); end
   endtask

   task automatic test_reset_mid_burst();
      int lat; logic [31:0] rd, exp; logic ga, ge, af;
      classic(adr_of(18), 1'b1, 32'h18181818, 4'hf, lat, rd, ga, ge, af);
      model_write(18, 32'h18181818, 4'hf);
      bus.wb_adr_i = adr_of(16); bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hf;
      bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00; bus.wb_dat_i = 32'h1600_0001;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
      tick();
      checks++; if (bus.wb_ack_o !== 1'b1) begin failures++; $display("FAIL rstb_first_ack: got %b expected 1", bus.wb_ack_o); end
      tick();
      bus.wb_dat_i = 32'h1700_0002;
      tick();
      bus.wb_dat_i = 32'h1800_0003;
      rst = 1'b1;
      tick();
      checks++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
         failures++; $display("FAIL rstb_outputs: got ack=%b err=%b dat=%h expected 0 0 00000000", bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o);
      end
      rst = 1'b0;
      bus_idle();
      tick();
      model_write(16, 32'h1600_0001, 4'hf);
      model_write(17, 32'h1700_0002, 4'hf);
      for (int i = 16; i <= 18; i++) begin
         sb_q.push_back(model[i]);
         classic(adr_of(i), 1'b0, 32'h0, 4'h0, lat, rd, ga, ge, af);
         exp = sb_q.pop_front();
         checks++; if (rd !== exp || lat !== 1) begin failures++; $display("FAIL rstb_readback idx %0d: got %h lat %0d expected %h lat 1", i, rd, lat, exp); end
      end
   endtask

   initial begin
      foreach (model[i]) model[i] = '0;
      bus_idle();
      test_reset();
      test_classic();
      test_wrap4();
      test_linear_write();
      test_out_of_range();
      test_wait_state();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
